// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default operand format for the divider datapath
package div_pkg;
  localparam int DIV_OPND_W = 16;
  localparam int DIV_FRAC_BITS = 8;
  typedef enum logic [1:0] {S_IDLE, S_DVD, S_DVS, S_OUT} state_t;
endpackage

// File: rtl/div_byte_shreg.sv
// div_byte_shreg: MSB-first byte shift register with clear and load
module div_byte_shreg #(
  parameter int OPND_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [7:0]        din,
  output logic [OPND_W-1:0] q
);
  // clear wins over load; load starts a new operand with din as its top byte-so-far
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (load) q <= OPND_W'(din);
    else if (shift) q <= (q << 8) | OPND_W'(din);
endmodule

// File: rtl/div_operand_framer.sv
// div_operand_framer: assembles byte frames into dividend/divisor pairs; OPERAND_DIVZERO_DROP_EN drops zero-divisor frames
module div_operand_framer import div_pkg::*; #(
  parameter int OPND_W = DIV_OPND_W,
  parameter int FRAC_BITS = DIV_FRAC_BITS
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [7:0]        i_data,
  input  logic              i_valid,
  input  logic              i_sof,
  output logic              o_ready,
  output logic [OPND_W-1:0] o_dividend,
  output logic [OPND_W-1:0] o_divisor,
  output logic              o_div_zero,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_frame_err
);
  localparam int NB = OPND_W / 8;
  if ((OPND_W % 8) != 0 || OPND_W < 8 || OPND_W > 32 || FRAC_BITS < 0 || FRAC_BITS >= OPND_W) begin : g_bad_cfg
    $error("div_operand_framer: unsupported OPND_W/FRAC_BITS");
  end
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic err_n, zero_n, acc, last, ld, sh_dvd, sh_dvs, clr_dvs, dvs_zero;
  logic [OPND_W-1:0] dvs_next;
  assign acc = i_valid && o_ready;
  assign last = cnt == 3'(NB - 1);
  assign dvs_next = (o_divisor << 8) | OPND_W'(i_data);
  assign dvs_zero = dvs_next == '0;
  div_byte_shreg #(.OPND_W(OPND_W)) u_dvd (
    .clk(i_clk), .rst_n(i_reset_n), .clr(1'b0), .load(ld), .shift(sh_dvd), .din(i_data), .q(o_dividend)
  );
  div_byte_shreg #(.OPND_W(OPND_W)) u_dvs (
    .clk(i_clk), .rst_n(i_reset_n), .clr(clr_dvs), .load(1'b0), .shift(sh_dvs), .din(i_data), .q(o_divisor)
  );
  // next state, byte steering and error pulse; an sof byte always restarts the frame
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    err_n = 1'b0;
    zero_n = o_div_zero;
    ld = 1'b0;
    sh_dvd = 1'b0;
    sh_dvs = 1'b0;
    clr_dvs = 1'b0;
    if (state == S_OUT) begin
      if (i_ready) state_n = S_IDLE;
    end else if (acc && i_sof) begin
      err_n = state != S_IDLE;
      ld = 1'b0 | 1'b1;
      clr_dvs = 1'b1;
      state_n = NB == 1 ? S_DVS : S_DVD;
      cnt_n = NB == 1 ? 3'd0 : 3'd1;
    end else if (acc && state == S_IDLE) begin
      err_n = 1'b1;
    end else if (acc && state == S_DVD) begin
      sh_dvd = 1'b1;
      state_n = last ? S_DVS : S_DVD;
      cnt_n = last ? 3'd0 : cnt + 3'd1;
    end else if (acc) begin
      sh_dvs = 1'b1;
      cnt_n = last ? 3'd0 : cnt + 3'd1;
      if (last) begin
`ifdef OPERAND_DIVZERO_DROP_EN
        state_n = dvs_zero ? S_IDLE : S_OUT;
        err_n = dvs_zero;
`else
        state_n = S_OUT;
        zero_n = dvs_zero;
`endif
      end
    end
  end
  // state and registered outputs; ready/valid are decoded from the next state so they track it exactly
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= S_IDLE;
      cnt <= '0;
      o_ready <= 1'b0;
      o_valid <= 1'b0;
      o_div_zero <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_ready <= state_n != S_OUT;
      o_valid <= state_n == S_OUT;
      o_div_zero <= zero_n;
      o_frame_err <= err_n;
    end
endmodule
